// File: rtl/mcu_ctrl_pkg.sv
// Shared constants for the MCU boot loader and pause controller.
// The state encoding is shared by the boot loader and the pause FSM.
package mcu_ctrl_pkg;

   localparam logic [2:0] ST_BOOT_ACCEPT = 3'd0;
   localparam logic [2:0] ST_BOOT_WRITE  = 3'd1;
   localparam logic [2:0] ST_RUN         = 3'd2;
   localparam logic [2:0] ST_PAUSING     = 3'd3;
   localparam logic [2:0] ST_PAUSED      = 3'd4;

   // Boot words are 16 bits wide, so each one advances the byte address by 2.
   localparam logic [15:0] BOOT_ADDR_STEP = 16'd2;

   localparam int BOOT_WORDS_DEFAULT = 32768;

endpackage

// File: rtl/mcu_boot_pause_ctrl_if.sv
// Boot stream, boot write port and pause handshake between the MCU controller and its environment.
// The controller takes the slave side; the environment drives the master side.
interface mcu_boot_pause_ctrl_if;

   logic [15:0] i_bootData;
   logic        i_bootValid;
   logic        o_bootReady;
   logic [15:0] o_memAddr;
   logic [15:0] o_memData;
   logic        o_memWr;
   logic        o_isBooted;
   logic        i_doPause;
   logic        o_startPause;
   logic        i_nowPaused;
   logic        i_dbgPause;
   logic        i_resume;
   logic        o_paused;

   modport slave (
      input  i_bootData, i_bootValid, i_doPause, i_nowPaused, i_dbgPause, i_resume,
      output o_bootReady, o_memAddr, o_memData, o_memWr, o_isBooted, o_startPause, o_paused
   );

   modport master (
      output i_bootData, i_bootValid, i_doPause, i_nowPaused, i_dbgPause, i_resume,
      input  o_bootReady, o_memAddr, o_memData, o_memWr, o_isBooted, o_startPause, o_paused
   );

endinterface

// File: rtl/mcu_boot_pause_ctrl_boot_loader.sv
// Boot image loader: accepts one word, writes it on the following cycle, and repeats until
// BOOT_WORDS words have been written, then raises o_done until reset.
module boot_loader
   import mcu_ctrl_pkg::*;
#(
   parameter int BOOT_WORDS = BOOT_WORDS_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_bootData,
   input  logic        i_bootValid,
   output logic        o_bootReady,
   output logic [15:0] o_memAddr,
   output logic [15:0] o_memData,
   output logic        o_memWr,
   output logic        o_done
);

   localparam logic [15:0] LP_LAST_COUNT = 16'(BOOT_WORDS);

   logic [2:0]  r_state;
   logic [15:0] r_count;
   logic [15:0] r_memAddr;
   logic [15:0] r_memData;
   logic        r_memWr;
   logic        r_bootReady;
   logic        r_done;
   logic [15:0] w_count_next;

   assign w_count_next = r_count + 16'd1;

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_BOOT_ACCEPT;
         r_count     <= '0;
         r_memAddr   <= '0;
         r_memData   <= '0;
         r_memWr     <= 1'b0;
         r_bootReady <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_BOOT_ACCEPT: begin
               if (i_bootValid) begin
                  r_memData   <= i_bootData;
                  r_memAddr   <= r_count * BOOT_ADDR_STEP;
                  r_memWr     <= 1'b1;
                  r_bootReady <= 1'b0;
                  r_state     <= ST_BOOT_WRITE;
               end
            end
            ST_BOOT_WRITE: begin
               r_memWr <= 1'b0;
               r_count <= w_count_next;
               // A 16-bit count lets 32768 words terminate at address 0xFFFE without wrapping.
               if (w_count_next == LP_LAST_COUNT) begin
                  r_done  <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  r_bootReady <= 1'b1;
                  r_state     <= ST_BOOT_ACCEPT;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_bootReady = r_bootReady;
   assign o_memAddr   = r_memAddr;
   assign o_memData   = r_memData;
   assign o_memWr     = r_memWr;
   assign o_done      = r_done;

endmodule

// File: rtl/mcu_boot_pause_ctrl.sv
// MCU boot and pause controller: loads the boot image, releases the core, then serves
// PSE and debug pause requests through the startPause/nowPaused handshake.
module mcu_boot_pause_ctrl
   import mcu_ctrl_pkg::*;
#(
   parameter int BOOT_WORDS = BOOT_WORDS_DEFAULT
) (
   input logic                 i_clk,
   input logic                 i_rst,
   mcu_boot_pause_ctrl_if.slave bus
);

   logic       w_boot_done;
   logic       w_request;
   logic       w_resume_ok;
   logic [2:0] r_state;
   logic       r_rearm;
   logic       r_startPause;
   logic       r_paused;

   boot_loader #(
      .BOOT_WORDS (BOOT_WORDS)
   ) u_boot_loader (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_bootData  (bus.i_bootData),
      .i_bootValid (bus.i_bootValid),
      .o_bootReady (bus.o_bootReady),
      .o_memAddr   (bus.o_memAddr),
      .o_memData   (bus.o_memData),
      .o_memWr     (bus.o_memWr),
      .o_done      (w_boot_done)
   );

   assign w_request   = (bus.i_doPause & r_rearm) | bus.i_dbgPause;
   assign w_resume_ok = (r_state == ST_PAUSED) & bus.i_resume & ~bus.i_dbgPause;

   // The pause FSM sits in RUN while the loader works and only advances once boot is done.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_RUN;
         r_startPause <= 1'b0;
         r_paused     <= 1'b0;
      end else if (w_boot_done) begin
         case (r_state)
            ST_RUN: begin
               if (w_request) begin
                  r_startPause <= 1'b1;
                  r_state      <= ST_PAUSING;
               end
            end
            ST_PAUSING: begin
               if (bus.i_nowPaused) begin
                  r_paused <= 1'b1;
                  r_state  <= ST_PAUSED;
               end
            end
            ST_PAUSED: begin
               if (w_resume_ok) begin
                  r_startPause <= 1'b0;
                  r_paused     <= 1'b0;
                  r_state      <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   // Rearm stays clear while the PSE that was just resumed keeps i_doPause high.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rearm <= 1'b1;
      end else if (!bus.i_doPause) begin
         r_rearm <= 1'b1;
      end else if (w_resume_ok) begin
         r_rearm <= 1'b0;
      end
   end

   assign bus.o_isBooted   = w_boot_done;
   assign bus.o_startPause = r_startPause;
   assign bus.o_paused     = r_paused;

endmodule

// File: tb/tb_mcu_boot_pause_ctrl.sv
// Self-checking bench for mcu_boot_pause_ctrl with a 4-word boot image: directed boot/pause
// steps plus a randomized pause phase compared against a behavioural model.
module tb_mcu_boot_pause_ctrl;

   localparam int N_WORDS = 4;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;
   wr_t  exp_q[$];
   wr_t  mon_e;
   int   model_count = 0;
   logic prev_wr = 1'b0;

   mcu_boot_pause_ctrl_if bus ();

   mcu_boot_pause_ctrl #(
      .BOOT_WORDS (N_WORDS)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pause(input logic dp, input logic dbg, input logic np, input logic rs);
      bus.i_doPause   = dp;
      bus.i_dbgPause  = dbg;
      bus.i_nowPaused = np;
      bus.i_resume    = rs;
   endtask

   // Every write must match the next word the bench handed over, at address index*2.
   always @(negedge clk) begin
      if (!rst && bus.o_memWr) begin
         check("wr_single_cycle", 64'(prev_wr), 64'(0));
         check("wr_expected", 64'(exp_q.size() > 0), 64'(1));
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 64'(bus.o_memAddr), 64'(mon_e.addr));
            check("wr_data", 64'(bus.o_memData), 64'(mon_e.data));
         end
      end
      prev_wr = bus.o_memWr;
   end

   task automatic send_word(input logic [15:0] d);
      int budget = 20;
      bit done = 1'b0;
      bus.i_bootData  = d;
      bus.i_bootValid = 1'b1;
      while (!done && budget > 0) begin
         if (bus.o_bootReady) begin
            exp_q.push_back('{addr: 16'(model_count * 2), data: d});
            model_count++;
            done = 1'b1;
         end
         tick();
         budget--;
      end
      check("handshake_in_budget", 64'(done), 64'(1));
   endtask

   // Called in the cycle after the last handshake (the final write cycle).
   task automatic finish_boot(input string tag);
      check({tag, "_booted_low_in_write"}, 64'(bus.o_isBooted), 64'(0));
      check({tag, "_last_wr"}, 64'(bus.o_memWr), 64'(1));
      tick();
      check({tag, "_booted"}, 64'(bus.o_isBooted), 64'(1));
      check({tag, "_ready_low"}, 64'(bus.o_bootReady), 64'(0));
   endtask

   task automatic pulse_reset(input string tag);
      check({tag, "_q_empty"}, 64'(exp_q.size()), 64'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check(tag, {27'b0, bus.o_bootReady, bus.o_memWr, bus.o_isBooted, bus.o_startPause,
                  bus.o_paused, bus.o_memAddr, bus.o_memData}, {27'b0, 5'b10000, 32'h0});
      model_count = 0;
   endtask

   // Reference: a request raises startPause, an ack raises paused, a qualifying resume clears
   // both; rearm follows i_doPause low and is consumed by a resume taken while i_doPause is high.
   task automatic run_random(input int n);
      logic m_start = 1'b0, m_paused = 1'b0, m_rearm = 1'b1;
      logic dp, dbg, np, rs, resume_ok;
      for (int i = 0; i < n; i++) begin
         dp  = ($urandom_range(0, 3) != 0);
         dbg = ($urandom_range(0, 7) == 0);
         np  = 1'($urandom_range(0, 1));
         rs  = ($urandom_range(0, 2) == 0);
         drive_pause(dp, dbg, np, rs);
         resume_ok = m_paused && rs && !dbg;
         if (!m_start) m_start = (dp && m_rearm) || dbg;
         else if (!m_paused) m_paused = np;
         else if (resume_ok) begin
            m_start  = 1'b0;
            m_paused = 1'b0;
         end
         if (!dp) m_rearm = 1'b1;
         else if (resume_ok) m_rearm = 1'b0;
         tick();
         check("rand_startPause", 64'(bus.o_startPause), 64'(m_start));
         check("rand_paused", 64'(bus.o_paused), 64'(m_paused));
      end
      drive_pause(0, 0, 0, 0);
   endtask

   initial begin
      logic [15:0] img [N_WORDS];
      img[0] = 16'h1111;
      img[1] = 16'h2222;
      img[2] = 16'h3333;
      img[3] = 16'h4444;
      bus.i_bootData  = '0;
      bus.i_bootValid = 1'b0;
      drive_pause(0, 0, 0, 0);
      pulse_reset("reset_initial");

      // Boot sequence with valid held, then valid kept high after boot must not write.
      for (int i = 0; i < N_WORDS; i++) send_word(img[i]);
      finish_boot("boot1");
      repeat (3) tick();
      bus.i_bootValid = 1'b0;

      // PSE pause, ack three cycles after the request, resume with i_doPause still high.
      bus.i_doPause = 1'b1;
      tick();
      check("pse_start", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b10));
      repeat (2) begin
         tick();
         check("pse_wait_ack", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b10));
      end
      bus.i_nowPaused = 1'b1;
      tick();
      check("pse_paused", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b11));
      bus.i_nowPaused = 1'b0;
      bus.i_resume    = 1'b1;
      tick();
      bus.i_resume = 1'b0;
      check("pse_resumed", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b00));
      repeat (5) begin
         tick();
         check("pse_no_repause", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b00));
      end
      drive_pause(0, 0, 1, 1);
      tick();
      check("run_ignores_ack_resume", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b00));
      drive_pause(1, 0, 0, 0);
      tick();
      check("pse_rearmed", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b10));
      bus.i_nowPaused = 1'b1;
      tick();
      check("pse2_paused", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b11));
      drive_pause(0, 0, 0, 1);
      tick();
      bus.i_resume = 1'b0;
      check("pse2_resumed", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b00));

      // Debug pause overrides resume until released.
      bus.i_dbgPause = 1'b1;
      tick();
      check("dbg_start", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b10));
      bus.i_nowPaused = 1'b1;
      tick();
      bus.i_nowPaused = 1'b0;
      check("dbg_paused", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b11));
      bus.i_resume = 1'b1;
      tick();
      bus.i_resume = 1'b0;
      check("dbg_resume_ignored", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b11));
      bus.i_dbgPause = 1'b0;
      tick();
      check("dbg_released_held", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b11));
      bus.i_resume = 1'b1;
      tick();
      bus.i_resume = 1'b0;
      check("dbg_resumed", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b00));

      tick();
      run_random(300);

      // Force PAUSED from any state, then reset.
      drive_pause(0, 1, 1, 0);
      repeat (3) tick();
      check("pre_reset_paused", 64'({bus.o_startPause, bus.o_paused}), 64'(2'b11));
      pulse_reset("reset_paused");
      drive_pause(0, 0, 0, 0);

      // Boot with a 5-cycle stall and pause noise mid-stream.
      repeat (2) send_word(16'($urandom));
      bus.i_bootValid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_pause(1'($urandom_range(0, 1)), (k == 2) || ($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         tick();
         check("stall_outputs", 64'({bus.o_memWr, bus.o_bootReady, bus.o_isBooted,
                                     bus.o_startPause, bus.o_paused}), 64'(5'b01000));
      end
      drive_pause(0, 0, 0, 0);
      repeat (2) send_word(16'($urandom));
      finish_boot("boot2");
      bus.i_bootValid = 1'b0;

      // Reset after 2 of 4 words; the boot restarts at address 0.
      pulse_reset("reset_before_boot3");
      repeat (2) send_word(16'($urandom));
      bus.i_bootValid = 1'b0;
      tick();
      pulse_reset("reset_mid_boot");
      for (int i = 0; i < N_WORDS; i++) send_word(16'($urandom));
      finish_boot("boot3");
      bus.i_bootValid = 1'b0;
      tick();
      check("writes_drained", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
